// File: rtl/id_ex_reg_if.sv
// Decode-to-execute bundle for the ID/EX pipeline register: decode-stage
// operands, fields and controls, the registered ex_* copies and the load-use stall.
interface id_ex_reg_if #(parameter int W = 32);
  logic         valid_in;
  logic [W-1:0] RD1;
  logic [W-1:0] RD2;
  logic [W-1:0] Imm;
  logic [4:0]   RS;
  logic [4:0]   RT;
  logic [4:0]   RD;
  logic         RegWrite;
  logic         MemRead;
  logic         MemWrite;
  logic         MemToReg;
  logic         RegDst;
  logic         ALUSrc;
  logic [2:0]   ALUOp;
  logic         Flush;

  logic [W-1:0] ex_RD1;
  logic [W-1:0] ex_RD2;
  logic [W-1:0] ex_Imm;
  logic [4:0]   ex_RS;
  logic [4:0]   ex_RT;
  logic [4:0]   ex_RD;
  logic         ex_RegWrite;
  logic         ex_MemRead;
  logic         ex_MemWrite;
  logic         ex_MemToReg;
  logic         ex_RegDst;
  logic         ex_ALUSrc;
  logic [2:0]   ex_ALUOp;
  logic         ex_valid;
  logic         stall;

  modport master (
    output valid_in, RD1, RD2, Imm, RS, RT, RD,
    output RegWrite, MemRead, MemWrite, MemToReg, RegDst, ALUSrc, ALUOp, Flush,
    input  ex_RD1, ex_RD2, ex_Imm, ex_RS, ex_RT, ex_RD,
    input  ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg, ex_RegDst, ex_ALUSrc,
    input  ex_ALUOp, ex_valid, stall
  );

  modport slave (
    input  valid_in, RD1, RD2, Imm, RS, RT, RD,
    input  RegWrite, MemRead, MemWrite, MemToReg, RegDst, ALUSrc, ALUOp, Flush,
    output ex_RD1, ex_RD2, ex_Imm, ex_RS, ex_RT, ex_RD,
    output ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg, ex_RegDst, ex_ALUSrc,
    output ex_ALUOp, ex_valid, stall
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with bubble insertion and load-use stall detection.
// Define ID_EX_HAZARD_DET_EN to enable the load-use hazard detector; otherwise stall is tied low.
module id_ex_reg #(
  parameter int W = 32
) (
  input  logic        clk,
  input  logic        reset,
  id_ex_reg_if.slave  bus
);

  logic [W-1:0] ex_rd1;
  logic [W-1:0] ex_rd2;
  logic [W-1:0] ex_imm;
  logic [4:0]   ex_rs;
  logic [4:0]   ex_rt;
  logic [4:0]   ex_rd;
  logic         ex_reg_write;
  logic         ex_mem_read;
  logic         ex_mem_write;
  logic         ex_mem_to_reg;
  logic         ex_reg_dst;
  logic         ex_alu_src;
  logic [2:0]   ex_alu_op;
  logic         ex_valid;
  logic         hazard;
  logic         bubble;

`ifdef ID_EX_HAZARD_DET_EN
  // Load in EX whose destination is read by the decode instruction; $0 never hazards.
  always_comb begin
    hazard = ex_valid && ex_mem_read && (ex_rt != 5'd0) &&
             ((ex_rt == bus.RS) || (ex_rt == bus.RT));
  end
`else
  // Software schedules load-use spacing in this build.
  always_comb begin
    hazard = 1'b0;
  end
`endif

  // Flush, stall and an empty decode slot all collapse into the same bubble.
  always_comb begin
    bubble = hazard || bus.Flush || !bus.valid_in;
  end

  // Pipeline register: data always loads, controls are zeroed on a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_rd1        <= '0;
      ex_rd2        <= '0;
      ex_imm        <= '0;
      ex_rs         <= 5'd0;
      ex_rt         <= 5'd0;
      ex_rd         <= 5'd0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_alu_op     <= 3'd0;
      ex_valid      <= 1'b0;
    end else begin
      ex_rd1 <= bus.RD1;
      ex_rd2 <= bus.RD2;
      ex_imm <= bus.Imm;
      ex_rs  <= bus.RS;
      ex_rt  <= bus.RT;
      ex_rd  <= bus.RD;
      if (bubble) begin
        ex_reg_write  <= 1'b0;
        ex_mem_read   <= 1'b0;
        ex_mem_write  <= 1'b0;
        ex_mem_to_reg <= 1'b0;
        ex_reg_dst    <= 1'b0;
        ex_alu_src    <= 1'b0;
        ex_alu_op     <= 3'd0;
        ex_valid      <= 1'b0;
      end else begin
        ex_reg_write  <= bus.RegWrite;
        ex_mem_read   <= bus.MemRead;
        ex_mem_write  <= bus.MemWrite;
        ex_mem_to_reg <= bus.MemToReg;
        ex_reg_dst    <= bus.RegDst;
        ex_alu_src    <= bus.ALUSrc;
        ex_alu_op     <= bus.ALUOp;
        ex_valid      <= 1'b1;
      end
    end
  end

  assign bus.ex_RD1      = ex_rd1;
  assign bus.ex_RD2      = ex_rd2;
  assign bus.ex_Imm      = ex_imm;
  assign bus.ex_RS       = ex_rs;
  assign bus.ex_RT       = ex_rt;
  assign bus.ex_RD       = ex_rd;
  assign bus.ex_RegWrite = ex_reg_write;
  assign bus.ex_MemRead  = ex_mem_read;
  assign bus.ex_MemWrite = ex_mem_write;
  assign bus.ex_MemToReg = ex_mem_to_reg;
  assign bus.ex_RegDst   = ex_reg_dst;
  assign bus.ex_ALUSrc   = ex_alu_src;
  assign bus.ex_ALUOp    = ex_alu_op;
  assign bus.ex_valid    = ex_valid;
  assign bus.stall       = hazard;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios plus randomized traffic
// against a model of "the instruction currently in EX".
module tb_id_ex_reg;
  localparam int W = 32;
`ifdef ID_EX_HAZARD_DET_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  id_ex_reg_if #(.W(W)) b ();
  id_ex_reg #(.W(W)) dut (.clk(clk), .reset(reset), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What the execute stage is expected to hold.
  typedef struct {
    bit        valid;
    bit        reg_write, mem_read, mem_write, mem_to_reg, reg_dst, alu_src;
    bit [2:0]  alu_op;
    bit [31:0] rd1, rd2, imm;
    bit [4:0]  rs, rt, rd;
  } instr_t;

  instr_t m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // A load in EX blocks a decode instruction that reads its (nonzero) target.
  function automatic bit model_stall();
    if (!HAZ_EN || !m.valid || !m.mem_read || m.rt == 5'd0) return 1'b0;
    return (m.rt == b.RS) || (m.rt == b.RT);
  endfunction

  task automatic clear_model();
    m = '{default: '0};
  endtask

  task automatic set_idle();
    b.valid_in = 1'b0; b.RD1 = '0; b.RD2 = '0; b.Imm = '0;
    b.RS = 5'd0; b.RT = 5'd0; b.RD = 5'd0;
    b.RegWrite = 1'b0; b.MemRead = 1'b0; b.MemWrite = 1'b0; b.MemToReg = 1'b0;
    b.RegDst = 1'b0; b.ALUSrc = 1'b0; b.ALUOp = 3'd0; b.Flush = 1'b0;
  endtask

  task automatic check_ex(input string tag);
    check({tag, ".valid"}, b.ex_valid, m.valid);
    check({tag, ".ctrl"},
          {b.ex_RegWrite, b.ex_MemRead, b.ex_MemWrite, b.ex_MemToReg, b.ex_RegDst, b.ex_ALUSrc, b.ex_ALUOp},
          {m.reg_write, m.mem_read, m.mem_write, m.mem_to_reg, m.reg_dst, m.alu_src, m.alu_op});
    if (m.valid) begin
      check({tag, ".rd1"}, b.ex_RD1, m.rd1);
      check({tag, ".rd2"}, b.ex_RD2, m.rd2);
      check({tag, ".imm"}, b.ex_Imm, m.imm);
      check({tag, ".fields"}, {b.ex_RS, b.ex_RT, b.ex_RD}, {m.rs, m.rt, m.rd});
    end
  endtask

  // One cycle: check stall mid-cycle, advance the model at the edge, check EX after it.
  task automatic step(input string tag, output bit stalled);
    bit st;
    @(negedge clk);
    st = model_stall();
    check({tag, ".stall"}, b.stall, st);
    stalled = st;
    @(posedge clk);
    if (st || b.Flush || !b.valid_in) begin
      m.valid = 1'b0; m.reg_write = 1'b0; m.mem_read = 1'b0; m.mem_write = 1'b0;
      m.mem_to_reg = 1'b0; m.reg_dst = 1'b0; m.alu_src = 1'b0; m.alu_op = 3'd0;
    end else begin
      m.valid = 1'b1; m.reg_write = b.RegWrite; m.mem_read = b.MemRead;
      m.mem_write = b.MemWrite; m.mem_to_reg = b.MemToReg; m.reg_dst = b.RegDst;
      m.alu_src = b.ALUSrc; m.alu_op = b.ALUOp;
      m.rd1 = b.RD1; m.rd2 = b.RD2; m.imm = b.Imm; m.rs = b.RS; m.rt = b.RT; m.rd = b.RD;
    end
    #1;
    check_ex(tag);
  endtask

  task automatic drive_lw(input bit [4:0] rs, input bit [4:0] rt);
    set_idle();
    b.valid_in = 1'b1; b.RS = rs; b.RT = rt; b.Imm = 32'h0000_0004;
    b.RegWrite = 1'b1; b.MemRead = 1'b1; b.MemToReg = 1'b1; b.ALUSrc = 1'b1; b.ALUOp = 3'b000;
  endtask

  task automatic drive_add(input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd);
    set_idle();
    b.valid_in = 1'b1; b.RS = rs; b.RT = rt; b.RD = rd;
    b.RD1 = 32'h0000_0111; b.RD2 = 32'h0000_0222;
    b.RegWrite = 1'b1; b.RegDst = 1'b1; b.ALUOp = 3'b010;
  endtask

  initial begin
    bit s;
    int stall_cycles;
    bit prev_s;
    checks = 0;
    errors = 0;
    clear_model();
    set_idle();

    // Power-on reset
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("por.valid", b.ex_valid, 1'b0);
    check("por.stall", b.stall, 1'b0);
    check("por.data", b.ex_RD1 | b.ex_RD2 | b.ex_Imm, 32'd0);
    reset = 1'b0;

    // Pass-through
    set_idle();
    b.valid_in = 1'b1; b.RD1 = 32'h0000_000A; b.RD2 = 32'h0000_0014;
    b.RegWrite = 1'b1; b.ALUOp = 3'b010;
    step("pass", s);
    check("pass.rd1", b.ex_RD1, 32'h0000_000A);
    check("pass.rd2", b.ex_RD2, 32'h0000_0014);
    check("pass.regwrite", b.ex_RegWrite, 1'b1);
    check("pass.aluop", b.ex_ALUOp, 3'b010);
    check("pass.valid", b.ex_valid, 1'b1);

    // Asynchronous reset mid-cycle while ex_RegWrite=1
    #2 reset = 1'b1;
    #1;
    check("arst.regwrite", b.ex_RegWrite, 1'b0);
    check("arst.valid", b.ex_valid, 1'b0);
    check("arst.stall", b.stall, 1'b0);
    check("arst.rd1", b.ex_RD1, 32'd0);
    reset = 1'b0;
    clear_model();

    // Load-use: lw $8 then add using $8
    drive_lw(5'd1, 5'd8);
    step("lu.lw", s);
    drive_add(5'd8, 5'd9, 5'd10);
    stall_cycles = 0;
    prev_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("lu.add", s);
      if (s) stall_cycles++;
      if (!s && !prev_s) break;
      prev_s = s;
    end
    check("lu.stall_cycles", stall_cycles, HAZ_EN ? 32'd1 : 32'd0);
    check("lu.captured_rs", b.ex_RS, 5'd8);
    check("lu.captured_valid", b.ex_valid, 1'b1);
    check("lu.captured_memread", b.ex_MemRead, 1'b0);

    // Load to $0 followed by a reader of $0
    drive_lw(5'd2, 5'd0);
    step("zero.lw", s);
    drive_add(5'd0, 5'd0, 5'd3);
    step("zero.add", s);
    check("zero.nostall", s, 1'b0);
    check("zero.captured", b.ex_valid, 1'b1);

    // Flush together with a load-use hazard, then normal capture
    drive_lw(5'd1, 5'd5);
    step("fl.lw", s);
    drive_add(5'd5, 5'd6, 5'd7);
    b.Flush = 1'b1;
    step("fl.both", s);
    check("fl.bubble", b.ex_valid, 1'b0);
    b.Flush = 1'b0;
    step("fl.next", s);
    check("fl.captured", b.ex_valid, 1'b1);

    // Reset asserted during an active hazard
    drive_lw(5'd1, 5'd12);
    step("rh.lw", s);
    drive_add(5'd4, 5'd12, 5'd13);
    #2;
    check("rh.pre_stall", b.stall, HAZ_EN ? 32'd1 : 32'd0);
    reset = 1'b1;
    #1;
    check("rh.stall", b.stall, 1'b0);
    check("rh.valid", b.ex_valid, 1'b0);
    reset = 1'b0;
    clear_model();
    step("rh.after", s);
    check("rh.captured_rt", b.ex_RT, 5'd12);

    // Stall with valid_in low: one bubble, nothing pending
    drive_lw(5'd1, 5'd20);
    step("sv.lw", s);
    drive_add(5'd20, 5'd0, 5'd1);
    b.valid_in = 1'b0;
    step("sv.bubble", s);
    set_idle();
    step("sv.idle", s);

    // Randomized traffic on a small register set to provoke hazards
    prev_s = 1'b0;
    for (int i = 0; i < 400; i++) begin
      b.valid_in = ($urandom_range(0, 9) != 0);
      b.Flush    = ($urandom_range(0, 9) == 0);
      b.RD1 = $urandom; b.RD2 = $urandom; b.Imm = $urandom;
      b.RS = 5'($urandom_range(0, 3)); b.RT = 5'($urandom_range(0, 3)); b.RD = 5'($urandom);
      b.RegWrite = 1'($urandom); b.MemRead = ($urandom_range(0, 2) == 0);
      b.MemWrite = 1'($urandom); b.MemToReg = 1'($urandom); b.RegDst = 1'($urandom);
      b.ALUSrc = 1'($urandom); b.ALUOp = 3'($urandom);
      step("rnd", s);
      if (s && prev_s) check("rnd.b2b_stall", {prev_s, s}, 2'b00);
      prev_s = s;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter W, default 32, the data width of every operand path.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, with asynchronous, active-high reset.
REQ-004 SHALL have input valid_in (1), high when the decode stage holds a real instruction.
REQ-005 SHALL have inputs RD1, RD2 (W each), the operands read from the register bank, and Imm (W), the sign-extended immediate.
REQ-006 SHALL have inputs RS, RT, RD (5 each), the instruction register fields; RS and RT are the same values driven to the bank's RR1 and RR2.
REQ-007 SHALL have control inputs RegWrite, MemRead, MemWrite, MemToReg, RegDst, ALUSrc (1 each) and ALUOp (3).
REQ-008 SHALL have input Flush (1), a branch-taken kill of the decode-stage instruction.
REQ-009 SHALL have outputs ex_RD1, ex_RD2, ex_Imm (W each), ex_RS, ex_RT, ex_RD (5 each), the registered copies.
REQ-010 SHALL have registered control outputs ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg, ex_RegDst, ex_ALUSrc (1 each), ex_ALUOp (3) and ex_valid (1).
REQ-011 SHALL have output stall (1), combinational, which freezes the PC and the IF/ID register.

Function
REQ-012 SHALL load all inputs into the ex_* registers on each rising clk edge when no bubble condition applies.
REQ-013 SHALL be a 1-cycle register: decode-stage values appear on ex_* the cycle after capture.
REQ-014 SHALL assert stall while all of the following hold:
- ex_valid=1,
- ex_MemRead=1,
- ex_RT!=0,
- ex_RT==RS or ex_RT==RT.
This is the load-use hazard condition.
REQ-015 SHALL insert a bubble on a clock edge where stall=1 or Flush=1 or valid_in=0: all ex_* control bits and ex_valid go to 0, and the data/field registers load normally (don't-care).
REQ-016 SHALL use stall only to hold upstream stages; the decode instruction SHALL be re-presented and captured the following cycle.
REQ-017 SHALL produce a one-cycle stall per load-use hazard, because the bubble clears ex_MemRead; back-to-back stalls for one instruction SHALL NOT occur.
REQ-018 SHALL give Flush priority over stall: with both high, the result is a bubble, and stall SHALL remain purely a function of REQ-014.
REQ-019 SHALL never generate a hazard on register 0, even when a load targets $0.
REQ-020 SHALL, on simultaneous stall and valid_in=0, produce a single bubble with no extra state.

Reset
REQ-021 SHALL, on reset=1, immediately and asynchronously clear every ex_* output to 0, including ex_valid=0.
REQ-022 SHALL drive stall=0 during and immediately after reset, since ex_valid=0.
REQ-023 SHALL, on reset asserted mid-hazard, cancel the stall in the same cycle; the first edge after release captures normally.

Configuration
REQ-024 SHALL, with macro ID_EX_HAZARD_DET_EN defined, implement REQ-014 through REQ-017 as written.
REQ-025 SHALL, with ID_EX_HAZARD_DET_EN undefined, tie stall to 0 and inject bubbles only from Flush and valid_in=0; the software scheduler is then responsible for load-use spacing.

Verification
REQ-026 SHALL cover reset: assert reset mid-cycle with ex_RegWrite=1 -> all ex_* =0 before the next edge, stall=0.
REQ-027 SHALL cover pass-through: RD1=0x0000_000A, RD2=0x0000_0014, RegWrite=1, ALUOp=3'b010 -> next cycle ex_RD1=0x0A, ex_RD2=0x14, ex_RegWrite=1, ex_ALUOp=3'b010, ex_valid=1.
REQ-028 SHALL cover load-use: lw to RT=8 followed by add with RS=8 -> stall=1 for exactly one cycle, bubble (ex_valid=0, all ex_* control bits=0), then the add is captured with stall=0.
REQ-029 SHALL cover the $0 case: lw to RT=0 followed by an instruction using RS=0 -> stall stays 0.
REQ-030 SHALL cover Flush priority: Flush=1 together with a load-use hazard -> bubble; Flush low next cycle -> normal capture.
REQ-031 SHALL cover the disabled build: without ID_EX_HAZARD_DET_EN, the REQ-028 stimulus -> stall=0 and the add is captured on the next edge.
